// File: rtl/duck_pkg.sv
// Shared constants for the duck sprite: image geometry, transparency key and ROM address width.
package duck_pkg;
  localparam int         DUCK_W      = 96;
  localparam int         DUCK_H      = 60;
  localparam int         DUCK_PIXELS = DUCK_W * DUCK_H;
  localparam logic [11:0] TRANSP_RGB = 12'h0F0;
  localparam int         ROM_AW      = 13;
endpackage

// File: rtl/draw_duck_if.sv
// Duck ROM read port: the drawer issues an address, the ROM answers with a colour one clock later.
interface draw_duck_if;
  import duck_pkg::*;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_rgb;

  modport master (output rom_addr, input rom_rgb);
  modport slave  (input rom_addr, output rom_rgb);
endinterface

// File: rtl/draw_duck_delay_line.sv
// Fixed-latency shift register with asynchronous active-low clear.
module delay_line #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [CLK_DEL-1:0][WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    shift_d    = shift_q;
    shift_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) shift_d[i] = shift_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shift_q <= '0;
    else        shift_q <= shift_d;
  end

  assign dout = shift_q[CLK_DEL-1];
endmodule

// File: rtl/draw_duck.sv
// Overlays the duck sprite on the VGA background stream, fetching one ROM pixel per clock.
// Position is latched on each vblnk rise so a frame never tears.
module draw_duck #(
  parameter int          DUCK_W = duck_pkg::DUCK_W,
  parameter int          DUCK_H = duck_pkg::DUCK_H,
  parameter logic [11:0] TRANSP = duck_pkg::TRANSP_RGB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        flip,
  input  logic        show,
  draw_duck_if.master rom,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam int AW = duck_pkg::ROM_AW;

  logic [10:0]   x_l_q, x_l_d, y_l_q, y_l_d;
  logic          flip_l_q, flip_l_d, show_l_q, show_l_d;
  logic          vblnk_prev_q, vblnk_prev_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [11:0]   rgb_out_q, rgb_out_d;

  logic [11:0]   dx, dy;
  logic [6:0]    col;
  logic          in_box;
  logic [AW-1:0] addr;

  always_comb begin
    x_l_d        = x_l_q;
    y_l_d        = y_l_q;
    flip_l_d     = flip_l_q;
    show_l_d     = show_l_q;
    vblnk_prev_d = vblnk_in;
    if (vblnk_in && !vblnk_prev_q) begin
      x_l_d    = xpos;
      y_l_d    = ypos;
      flip_l_d = flip;
      show_l_d = show;
    end
  end

  // Stage 1: 12-bit offsets; an offset below the origin wraps huge, so one unsigned compare covers both bounds.
  always_comb begin
    dx         = {1'b0, hcount_in} - {1'b0, x_l_q};
    dy         = {1'b0, vcount_in} - {1'b0, y_l_q};
    in_box     = show_l_q && (dx < 12'(DUCK_W)) && (dy < 12'(DUCK_H));
    col        = flip_l_q ? (7'(DUCK_W - 1) - dx[6:0]) : dx[6:0];
    addr       = {dy[6:0], 6'b0} + {1'b0, dy[6:0], 5'b0} + {6'b0, col};
    rom_addr_d = in_box ? addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l_q        <= '0;
      y_l_q        <= '0;
      flip_l_q     <= 1'b0;
      show_l_q     <= 1'b0;
      vblnk_prev_q <= 1'b0;
      rom_addr_q   <= '0;
      rgb_out_q    <= '0;
    end else begin
      x_l_q        <= x_l_d;
      y_l_q        <= y_l_d;
      flip_l_q     <= flip_l_d;
      show_l_q     <= show_l_d;
      vblnk_prev_q <= vblnk_prev_d;
      rom_addr_q   <= rom_addr_d;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;

  logic [25:0] timing_d3;
  logic [12:0] pix_d2;
  logic        in_box_d2;
  logic [11:0] rgb_d2;

  delay_line #(.WIDTH(26), .CLK_DEL(3)) u_timing_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({hsync_in, vsync_in, hblnk_in, vblnk_in, hcount_in, vcount_in}),
    .dout (timing_d3)
  );

  delay_line #(.WIDTH(13), .CLK_DEL(2)) u_pix_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({in_box, rgb_in}),
    .dout (pix_d2)
  );

  // Stage 3: ROM data has just landed, aligned with the pixel delayed two clocks.
  always_comb begin
    in_box_d2 = pix_d2[12];
    rgb_d2    = pix_d2[11:0];
    rgb_out_d = (in_box_d2 && (rom.rom_rgb != TRANSP)) ? rom.rom_rgb : rgb_d2;
  end

  assign {hsync_out, vsync_out, hblnk_out, vblnk_out, hcount_out, vcount_out} = timing_d3;
  assign rgb_out = rgb_out_q;
endmodule
